// File: rtl/print_string_unit.sv
// print_string_unit: walks a NUL-terminated, big-endian packed string in data
// memory one word at a time and streams its characters over a valid/ready port.
//
// Handshake: char_valid is asserted with a stable char_out; the character
// transfers on a rising edge where char_valid && char_ready are both high.
// char_out and char_valid never depend combinationally on char_ready.
module print_string_unit #(
    parameter logic [31:0] MEM_LO    = 32'h7FF00000,
    parameter logic [31:0] MEM_HI    = 32'h7FFFFFFF,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] start_addr,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  dbg_state
);

    // Wide enough to hold the value MAX_WORDS itself.
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EMIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     cur_addr_q, cur_addr_d;
    logic [31:0]     word_reg_q, word_reg_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [CW-1:0]   word_cnt_q, word_cnt_d;
    logic            err_q, err_d;
    logic [7:0]      sel_byte;

    // Big-endian byte select out of the captured word.
    always_comb begin
        sel_byte = 8'h00;
        case (byte_idx_q)
            2'd0: sel_byte = word_reg_q[31:24];
            2'd1: sel_byte = word_reg_q[23:16];
            2'd2: sel_byte = word_reg_q[15:8];
            2'd3: sel_byte = word_reg_q[7:0];
            default: sel_byte = 8'h00;
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_addr_q <= 32'h0;
            word_reg_q <= 32'h0;
            byte_idx_q <= 2'd0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            word_reg_q <= word_reg_d;
            byte_idx_q <= byte_idx_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic and outputs.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        word_reg_d = word_reg_q;
        byte_idx_d = byte_idx_q;
        word_cnt_d = word_cnt_q;
        err_d      = err_q;
        char_valid = 1'b0;
        char_out   = 8'h00;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d = start_addr;
                    word_cnt_d = '0;
                    if (start_addr < MEM_LO) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        err_d   = 1'b0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                word_reg_d = mem_rdata;
                byte_idx_d = 2'd0;
                word_cnt_d = word_cnt_q + CW'(1);
                state_d    = EMIT;
            end
            EMIT: begin
                if (sel_byte == 8'h00) begin
                    // Terminator: never shown to the consumer.
                    state_d = FINISH;
                end else begin
                    char_valid = 1'b1;
                    char_out   = sel_byte;
                    if (char_ready) begin
                        if (byte_idx_q != 2'd3) begin
                            byte_idx_d = byte_idx_q + 2'd1;
                        end else if ((cur_addr_q == MEM_HI) ||
                                     (word_cnt_q == CW'(MAX_WORDS))) begin
                            // Ran off the end of memory or hit the word limit.
                            err_d   = 1'b1;
                            state_d = FINISH;
                        end else begin
                            cur_addr_d = cur_addr_q + 32'd1;
                            state_d    = FETCH;
                        end
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr  = cur_addr_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_print_string_unit.sv
// Bench for print_string_unit: directed strings in a fixed memory image, with a
// scoreboard monitor that checks every accepted character and every done/err.
module tb_print_string_unit;

    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_addr = 32'h0;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  dbg_state;

    logic [7:0] exp_q[$];
    logic       exp_err_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cnt = 0;
    int fetch_cnt = 0;
    int done_cnt = 0;

    print_string_unit dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .char_out(char_out),
        .char_valid(char_valid), .char_ready(char_ready), .busy(busy),
        .done(done), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Fixed memory image used by all tests.
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a >= 32'h7FF01000 && a <= 32'h7FF01FFF) return 32'h61626364;
        case (a)
            32'h7FFFFFF5: return 32'h68656c6c;
            32'h7FFFFFF6: return 32'h6f20776f;
            32'h7FFFFFF7: return 32'h726c6400;
            32'h7FF00010: return 32'h00414243;
            32'h7FFFFFFF: return 32'h41424344;
            default:      return 32'h00000000;
        endcase
    endfunction

    always_comb mem_rdata = mem_read(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic do_start(input logic [31:0] a);
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = a;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (k < budget) begin
            @(negedge clk);
            if (done) break;
            k++;
        end
        if (k >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: no done within %0d cycles", budget);
        end
    endtask

    // Monitor / scoreboard: pops expectations whenever the DUT presents output.
    initial begin
        logic [7:0] e;
        logic       ee;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (dbg_state == ST_FETCH) fetch_cnt++;
                if (char_valid && char_out == 8'h00) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL nul_emit: got char_out 00 with char_valid=1");
                end
                if (char_valid && char_ready) begin
                    acc_cnt++;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL char_extra: got %h expected none", char_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (char_out !== e) begin
                            n_bad++;
                            $display("FAIL char: got %h expected %h", char_out, e);
                        end
                    end
                end
                if (done) begin
                    done_cnt++;
                    n_cmp++;
                    if (exp_err_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL done_extra: got done with err=%b expected no done", err);
                    end else begin
                        ee = exp_err_q.pop_front();
                        if (err !== ee) begin
                            n_bad++;
                            $display("FAIL done_err: got %b expected %b", err, ee);
                        end
                    end
                    n_cmp++;
                    if (exp_q.size() != 0) begin
                        n_bad++;
                        $display("FAIL chars_left: got %0d pending expected 0", exp_q.size());
                    end
                end
            end
        end
    end

    initial begin
        int f0, d0, k;

        // Reset state.
        #2;
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_char_out", {24'h0, char_out}, 32'h0);
        check("rst_valid", {31'h0, char_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // "hello world" with ready held high; latency and fetch count.
        push_str("hello world");
        exp_err_q.push_back(1'b0);
        f0 = fetch_cnt;
        do_start(32'h7FFFFFF5);
        @(negedge clk);
        check("lat_fetch_busy", {31'h0, busy}, 32'h1);
        check("lat_fetch_valid", {31'h0, char_valid}, 32'h0);
        @(negedge clk);
        check("lat_first_valid", {31'h0, char_valid}, 32'h1);
        check("lat_first_char", {24'h0, char_out}, 32'h68);
        wait_done(200);
        check("hello_fetches", fetch_cnt - f0, 32'd3);

        // Consumer stalls on 'e' for three cycles.
        push_str("hello world");
        exp_err_q.push_back(1'b0);
        do_start(32'h7FFFFFF5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        char_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", {31'h0, char_valid}, 32'h1);
            check("stall_char", {24'h0, char_out}, 32'h65);
            @(posedge clk); #1;
        end
        char_ready = 1'b1;
        wait_done(200);

        // Empty string: NUL in the first byte.
        exp_err_q.push_back(1'b0);
        do_start(32'h7FF00010);
        @(negedge clk);
        @(negedge clk);
        check("nul_valid", {31'h0, char_valid}, 32'h0);
        check("nul_done_early", {31'h0, done}, 32'h0);
        @(negedge clk);
        check("nul_done", {31'h0, done}, 32'h1);

        // Last word of memory: "ABCD" then error; start while busy ignored.
        push_str("ABCD");
        exp_err_q.push_back(1'b1);
        do_start(32'h7FFFFFFF);
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = 32'h7FF00010;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        check("hi_mem_addr", mem_addr, 32'h7FFFFFFF);
        // Start during FINISH must be ignored.
        start = 1'b1;
        start_addr = 32'h0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("finish_start_ign", {31'h0, busy}, 32'h0);

        // Address below MEM_LO: immediate error, no fetch.
        exp_err_q.push_back(1'b1);
        f0 = fetch_cnt;
        do_start(32'h00000000);
        @(negedge clk);
        check("lo_done", {31'h0, done}, 32'h1);
        check("lo_err", {31'h0, err}, 32'h1);
        check("lo_state", {30'h0, dbg_state}, {30'h0, ST_FINISH});
        check("lo_fetches", fetch_cnt - f0, 32'd0);
        push_str("hello world");
        exp_err_q.push_back(1'b0);
        do_start(32'h7FFFFFF5);
        @(negedge clk);
        check("err_cleared", {31'h0, err}, 32'h0);
        wait_done(200);

        // Reset during the second word aborts without done.
        push_str("hello world");
        exp_err_q.push_back(1'b0);
        d0 = done_cnt;
        f0 = acc_cnt;
        do_start(32'h7FFFFFF5);
        k = 0;
        while (acc_cnt < f0 + 5 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("abort_reached", {31'h0, (k < 100)}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_valid", {31'h0, char_valid}, 32'h0);
        check("abort_mem_addr", mem_addr, 32'h0);
        exp_q.delete();
        exp_err_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 32'd0);
        push_str("hello world");
        exp_err_q.push_back(1'b0);
        do_start(32'h7FFFFFF5);
        @(negedge clk);
        @(negedge clk);
        check("restart_first", {24'h0, char_out}, 32'h68);
        wait_done(200);

        // Word limit: 256 words of "abcd" then error.
        for (int i = 0; i < 256; i++) push_str("abcd");
        exp_err_q.push_back(1'b1);
        do_start(32'h7FF01000);
        wait_done(1500);
        check("max_mem_addr", mem_addr, 32'h7FF010FF);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
